// File: rtl/ocimem_debug_ctrl_if.sv
// Bundle between the debug slave / CPU and the OCI debug RAM controller.
// Carries decoded JTAG commands, monitor status and the CPU-side RAM port.
interface ocimem_debug_ctrl_if #(
   parameter int ADDR_W = 8
);
   logic [37:0]       jdo;
   logic              take_action_ocimem_a;
   logic              take_action_ocimem_b;
   logic              take_no_action_ocimem_a;
   logic [31:0]       MonDReg;
   logic              monitor_ready;
   logic              monitor_error;
   logic [ADDR_W-1:0] cpu_address;
   logic              cpu_read;
   logic              cpu_write;
   logic [31:0]       cpu_writedata;
   logic              cpu_waitrequest;
   logic [31:0]       cpu_readdata;
   logic              cpu_readdatavalid;

   modport slave (
      input  jdo,
      input  take_action_ocimem_a,
      input  take_action_ocimem_b,
      input  take_no_action_ocimem_a,
      output MonDReg,
      output monitor_ready,
      output monitor_error,
      input  cpu_address,
      input  cpu_read,
      input  cpu_write,
      input  cpu_writedata,
      output cpu_waitrequest,
      output cpu_readdata,
      output cpu_readdatavalid
   );

   modport master (
      output jdo,
      output take_action_ocimem_a,
      output take_action_ocimem_b,
      output take_no_action_ocimem_a,
      input  MonDReg,
      input  monitor_ready,
      input  monitor_error,
      output cpu_address,
      output cpu_read,
      output cpu_write,
      output cpu_writedata,
      input  cpu_waitrequest,
      input  cpu_readdata,
      input  cpu_readdatavalid
   );
endinterface

// File: rtl/ocimem_debug_ctrl.sv
// OCI debug RAM controller: executes JTAG address/data/read-next commands
// against the debug RAM and shares that RAM with a stallable CPU port.
module ocimem_debug_ctrl #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic clk,
   input  logic reset,
   ocimem_debug_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      RD_DONE
   } state_t;

   localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W-1:0] mon_a;
   logic [ADDR_W-1:0] mon_a_inc;
   logic [31:0]       mem [DEPTH];
   logic [31:0]       rd_q;
   logic              rd_inc;

   logic idle;
   logic any_cmd;
   logic cmd_a;
   logic cmd_b;
   logic cmd_n;
   logic cmd_any;
   logic a_ok;
   logic cpu_ok;
   logic dbg_wr;
   logic cpu_acc;
   logic cpu_wr;
   logic cpu_rd;
   logic unused_jdo;

   // Command decode: priority a > b > n, only honoured while idle
   always_comb begin
      idle      = (state == IDLE);
      any_cmd   = bus.take_action_ocimem_a
                | bus.take_action_ocimem_b
                | bus.take_no_action_ocimem_a;
      cmd_a     = idle && bus.take_action_ocimem_a;
      cmd_b     = idle && !bus.take_action_ocimem_a
                       && bus.take_action_ocimem_b;
      cmd_n     = idle && !bus.take_action_ocimem_a
                       && !bus.take_action_ocimem_b
                       && bus.take_no_action_ocimem_a;
      cmd_any   = cmd_a | cmd_b | cmd_n;
      a_ok      = ({1'b0, mon_a} < DEPTH_L);
      cpu_ok    = ({1'b0, bus.cpu_address} < DEPTH_L);
      mon_a_inc = (mon_a == LAST) ? '0 : mon_a + 1'b1;
      dbg_wr    = cmd_b && bus.jdo[35] && a_ok;
      bus.cpu_waitrequest = !idle || any_cmd;
      cpu_acc   = !bus.cpu_waitrequest;
      cpu_wr    = cpu_acc && bus.cpu_write && cpu_ok;
      cpu_rd    = cpu_acc && bus.cpu_read && !bus.cpu_write;
   end

   assign unused_jdo = ^{bus.jdo[37:36], bus.jdo[1:0]};

   // Next-state logic for the debug read sequencer
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if ((cmd_a && bus.jdo[34])
                || (cmd_b && !bus.jdo[35])
                || cmd_n)
               state_nx = RD_WAIT;
         end
         RD_WAIT: state_nx = RD_DONE;
         RD_DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State, address register and monitor status
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state             <= IDLE;
         mon_a             <= '0;
         rd_inc            <= 1'b0;
         bus.MonDReg       <= '0;
         bus.monitor_ready <= 1'b1;
         bus.monitor_error <= 1'b0;
      end else begin
         state             <= state_nx;
         bus.monitor_ready <= !cmd_any && (state_nx == IDLE);
         if (!idle && any_cmd)
            bus.monitor_error <= 1'b1;
         if (cmd_a) begin
            mon_a             <= bus.jdo[ADDR_W+1:2];
            bus.monitor_error <= 1'b0;
            rd_inc            <= 1'b0;
         end
         if (cmd_b || cmd_n)
            rd_inc <= 1'b1;
         if (cmd_b && bus.jdo[35]) begin
            if (a_ok)
               mon_a <= mon_a_inc;
            else
               bus.monitor_error <= 1'b1;
         end
         if (state == RD_DONE) begin
            if (a_ok) begin
               bus.MonDReg <= rd_q;
               if (rd_inc)
                  mon_a <= mon_a_inc;
            end else begin
               bus.monitor_error <= 1'b1;
            end
         end
      end
   end

   // RAM array: one write port, registered debug-side read
   always_ff @(posedge clk) begin
      if (dbg_wr)
         mem[mon_a] <= bus.jdo[34:3];
      else if (cpu_wr)
         mem[bus.cpu_address] <= bus.cpu_writedata;
      rd_q <= mem[mon_a];
   end

   // CPU read return path, one cycle after acceptance
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.cpu_readdata      <= '0;
         bus.cpu_readdatavalid <= 1'b0;
      end else begin
         bus.cpu_readdatavalid <= cpu_rd;
         if (cpu_rd)
            bus.cpu_readdata <= cpu_ok ? mem[bus.cpu_address] : '0;
      end
   end

endmodule

// File: tb/tb_ocimem_debug_ctrl.sv
// Bench for ocimem_debug_ctrl (DEPTH=200): table of debug/CPU operations
// followed by hand-built latency, busy-drop, priority and reset sequences.
module tb_ocimem_debug_ctrl;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   ocimem_debug_ctrl_if #(.ADDR_W(8)) bus ();

   ocimem_debug_ctrl #(.DEPTH(200), .ADDR_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef enum {OP_A, OP_AR, OP_W, OP_BR, OP_N, OP_CR, OP_CW} op_e;

   typedef struct {
      op_e         op;
      logic [7:0]  addr;
      logic [31:0] data;
      logic [31:0] exp;
      logic        err;
   } vec_t;

   vec_t vt[$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [37:0] jdo_a(input logic [7:0] a,
                                         input logic rd);
      logic [37:0] j;
      j = '0;
      j[9:2] = a;
      j[34] = rd;
      return j;
   endfunction

   function automatic logic [37:0] jdo_w(input logic [31:0] d);
      logic [37:0] j;
      j = '0;
      j[35] = 1'b1;
      j[34:3] = d;
      return j;
   endfunction

   task automatic cmd(input logic a, input logic b, input logic n,
                      input logic [37:0] j);
      @(negedge clk);
      bus.jdo = j;
      bus.take_action_ocimem_a = a;
      bus.take_action_ocimem_b = b;
      bus.take_no_action_ocimem_a = n;
      @(negedge clk);
      bus.take_action_ocimem_a = 1'b0;
      bus.take_action_ocimem_b = 1'b0;
      bus.take_no_action_ocimem_a = 1'b0;
   endtask

   task automatic cpu_rd(input logic [7:0] a, output logic [31:0] d,
                         output logic v);
      @(negedge clk);
      bus.cpu_address = a;
      bus.cpu_read = 1'b1;
      @(negedge clk);
      bus.cpu_read = 1'b0;
      d = bus.cpu_readdata;
      v = bus.cpu_readdatavalid;
   endtask

   task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.cpu_address = a;
      bus.cpu_writedata = d;
      bus.cpu_write = 1'b1;
      @(negedge clk);
      bus.cpu_write = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      logic        v;
      bit          done;

      bus.jdo = '0;
      bus.take_action_ocimem_a = 1'b0;
      bus.take_action_ocimem_b = 1'b0;
      bus.take_no_action_ocimem_a = 1'b0;
      bus.cpu_address = '0;
      bus.cpu_read = 1'b0;
      bus.cpu_write = 1'b0;
      bus.cpu_writedata = '0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      chk("rst_mondreg", bus.MonDReg, 32'h0);
      chk("rst_ready", 32'(bus.monitor_ready), 32'h1);
      chk("rst_error", 32'(bus.monitor_error), 32'h0);
      chk("rst_waitreq", 32'(bus.cpu_waitrequest), 32'h0);
      chk("rst_rdvalid", 32'(bus.cpu_readdatavalid), 32'h0);
      chk("rst_rdata", bus.cpu_readdata, 32'h0);

      vt.push_back('{OP_A,  8'h10, 32'h0,        32'h0,        1'b0});
      vt.push_back('{OP_W,  8'h00, 32'hDEADBEEF, 32'h0,        1'b0});
      vt.push_back('{OP_W,  8'h00, 32'h12345678, 32'h0,        1'b0});
      vt.push_back('{OP_W,  8'h00, 32'hCAFEF00D, 32'h0,        1'b0});
      vt.push_back('{OP_CR, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0});
      vt.push_back('{OP_CR, 8'h11, 32'h0,        32'h12345678, 1'b0});
      vt.push_back('{OP_CR, 8'h12, 32'h0,        32'hCAFEF00D, 1'b0});
      vt.push_back('{OP_AR, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0});
      vt.push_back('{OP_N,  8'h00, 32'h0,        32'hDEADBEEF, 1'b0});
      vt.push_back('{OP_N,  8'h00, 32'h0,        32'h12345678, 1'b0});
      vt.push_back('{OP_N,  8'h00, 32'h0,        32'hCAFEF00D, 1'b0});
      vt.push_back('{OP_A,  8'h11, 32'h0,        32'h0,        1'b0});
      vt.push_back('{OP_BR, 8'h00, 32'h0,        32'h12345678, 1'b0});
      vt.push_back('{OP_A,  8'd199, 32'h0,       32'h0,        1'b0});
      vt.push_back('{OP_W,  8'h00, 32'h1,        32'h0,        1'b0});
      vt.push_back('{OP_W,  8'h00, 32'h2,        32'h0,        1'b0});
      vt.push_back('{OP_CR, 8'd199, 32'h0,       32'h1,        1'b0});
      vt.push_back('{OP_CR, 8'h00, 32'h0,        32'h2,        1'b0});
      vt.push_back('{OP_A,  8'd250, 32'h0,       32'h0,        1'b0});
      vt.push_back('{OP_W,  8'h00, 32'h55,       32'h0,        1'b1});
      vt.push_back('{OP_N,  8'h00, 32'h0,        32'h12345678, 1'b1});
      vt.push_back('{OP_CR, 8'd250, 32'h0,       32'h0,        1'b1});
      vt.push_back('{OP_CR, 8'h00, 32'h0,        32'h2,        1'b1});
      vt.push_back('{OP_A,  8'h05, 32'h0,        32'h0,        1'b0});
      vt.push_back('{OP_CW, 8'h20, 32'hA5A5A5A5, 32'h0,        1'b0});
      vt.push_back('{OP_CR, 8'h20, 32'h0,        32'hA5A5A5A5, 1'b0});
      vt.push_back('{OP_CW, 8'd220, 32'h9,       32'h0,        1'b0});
      vt.push_back('{OP_CR, 8'd220, 32'h0,       32'h0,        1'b0});

      for (int i = 0; i < vt.size(); i++) begin
         case (vt[i].op)
            OP_A:  cmd(1'b1, 1'b0, 1'b0, jdo_a(vt[i].addr, 1'b0));
            OP_W:  cmd(1'b0, 1'b1, 1'b0, jdo_w(vt[i].data));
            OP_CW: cpu_wr(vt[i].addr, vt[i].data);
            OP_CR: begin
               cpu_rd(vt[i].addr, d, v);
               chk($sformatf("v%0d_cpu_valid", i), 32'(v), 32'h1);
               chk($sformatf("v%0d_cpu_data", i), d, vt[i].exp);
            end
            default: begin
               if (vt[i].op == OP_AR)
                  cmd(1'b1, 1'b0, 1'b0, jdo_a(vt[i].addr, 1'b1));
               else if (vt[i].op == OP_BR)
                  cmd(1'b0, 1'b1, 1'b0, 38'h0);
               else
                  cmd(1'b0, 1'b0, 1'b1, 38'h0);
               repeat (2) @(negedge clk);
               chk($sformatf("v%0d_mondreg", i), bus.MonDReg, vt[i].exp);
            end
         endcase
         chk($sformatf("v%0d_error", i), 32'(bus.monitor_error),
             32'(vt[i].err));
      end
      chk("mon_a_after_table", 32'(dut.mon_a), 32'h5);

      // read latency and ready shape
      cmd(1'b1, 1'b0, 1'b0, jdo_a(8'h12, 1'b0));
      @(negedge clk);
      bus.take_no_action_ocimem_a = 1'b1;
      @(negedge clk);
      bus.take_no_action_ocimem_a = 1'b0;
      chk("lat_ready_n1", 32'(bus.monitor_ready), 32'h0);
      @(negedge clk);
      chk("lat_ready_n2", 32'(bus.monitor_ready), 32'h0);
      chk("lat_mondreg_n2", bus.MonDReg, 32'h12345678);
      @(negedge clk);
      chk("lat_mondreg_n3", bus.MonDReg, 32'hCAFEF00D);
      chk("lat_ready_n3", 32'(bus.monitor_ready), 32'h1);

      // write pulses ready low exactly one cycle
      cmd(1'b0, 1'b1, 1'b0, jdo_w(32'h77));
      chk("wr_ready_low", 32'(bus.monitor_ready), 32'h0);
      @(negedge clk);
      chk("wr_ready_back", 32'(bus.monitor_ready), 32'h1);
      cpu_rd(8'h13, d, v);
      chk("wr_readback", d, 32'h77);

      // second pulse while busy is dropped; CPU stalls until idle
      cmd(1'b1, 1'b0, 1'b0, jdo_a(8'h10, 1'b0));
      @(negedge clk);
      bus.jdo = '0;
      bus.take_action_ocimem_b = 1'b1;
      @(negedge clk);
      bus.take_action_ocimem_b = 1'b0;
      bus.take_no_action_ocimem_a = 1'b1;
      bus.cpu_address = 8'h13;
      bus.cpu_read = 1'b1;
      #1;
      chk("busy_waitreq", 32'(bus.cpu_waitrequest), 32'h1);
      @(negedge clk);
      bus.take_no_action_ocimem_a = 1'b0;
      chk("busy_error", 32'(bus.monitor_error), 32'h1);
      chk("busy_waitreq_done", 32'(bus.cpu_waitrequest), 32'h1);
      done = 1'b0;
      for (int k = 0; k < 8 && !done; k++) begin
         if (!bus.cpu_waitrequest)
            done = 1'b1;
         else
            @(negedge clk);
      end
      chk("busy_wait_bound", 32'(done), 32'h1);
      @(negedge clk);
      bus.cpu_read = 1'b0;
      chk("busy_cpu_valid", 32'(bus.cpu_readdatavalid), 32'h1);
      chk("busy_cpu_data", bus.cpu_readdata, 32'h77);
      chk("busy_mondreg", bus.MonDReg, 32'hDEADBEEF);
      chk("busy_mon_a", 32'(dut.mon_a), 32'h11);

      // coincident a and b: a wins, b dropped silently
      cpu_wr(8'h30, 32'h0);
      cmd(1'b1, 1'b1, 1'b0, jdo_a(8'h30, 1'b0) | 38'h8_0000_0000);
      chk("prio_error", 32'(bus.monitor_error), 32'h0);
      chk("prio_mon_a", 32'(dut.mon_a), 32'h30);
      cpu_rd(8'h30, d, v);
      chk("prio_ram", d, 32'h0);

      // asynchronous reset in the middle of a read
      cmd(1'b0, 1'b0, 1'b1, 38'h0);
      #2;
      reset = 1'b1;
      #1;
      chk("rst_mid_mondreg", bus.MonDReg, 32'h0);
      chk("rst_mid_ready", 32'(bus.monitor_ready), 32'h1);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_mid_lost", bus.MonDReg, 32'h0);
      chk("rst_mid_ready2", 32'(bus.monitor_ready), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
